circuit3_test_sequencer: RTL and testbench

Clocked fault-analysis controller for the 5-input, 1-output combinational circuit-under-test (CUT, x1..x5 -> z).
- Drives all 2^N_IN input vectors exhaustively into the CUT.
- Waits a programmable settle time per vector, then compares CUT z against a golden (fault-free) instance.
- Reports mismatch count, first failing vector and pass/fail.
- Sits between the bench/top level and the CUT plus golden model pair.

---
 rtl/circuit3_tst_pkg.sv | 21 ++
 rtl/circuit3_tst_result_log.sv | 71 +++++++
 rtl/circuit3_test_sequencer.sv | 134 +++++++++++++
 tb/tb_circuit3_test_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/circuit3_tst_pkg.sv
// Shared types, defaults and helpers for the circuit3 exhaustive test sequencer.
package circuit3_tst_pkg;

  localparam int unsigned N_IN_DEF       = 5;
  localparam int unsigned SETTLE_CYC_DEF = 2;
  localparam int unsigned SETTLE_W       = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Index of the final vector in an exhaustive sweep over n_in inputs.
  function automatic int unsigned vec_last(input int unsigned n_in);
    return (32'd1 << n_in) - 32'd1;
  endfunction

endpackage

// File: rtl/circuit3_tst_result_log.sv
// Result logger: mismatch detection, saturating error count, first-fail capture
// and pass flag generation for the circuit3 test sequencer.
module circuit3_tst_result_log
  import circuit3_tst_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            sample,
  input  logic            finalize,
  input  logic            cut_z,
  input  logic            gold_z,
  input  logic [N_IN-1:0] vec,
  output logic            mismatch_c,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid,
  output logic            pass
);

  localparam int unsigned ERR_W = N_IN + 1;

  logic [ERR_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic             ffval_q, ffval_d;
  logic             pass_q, pass_d;

  assign mismatch_c = sample & (cut_z ^ gold_z);

  // pass is resolved from err_d so a mismatch in the final compare is included
  always_comb begin
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    pass_d  = pass_q;
    if (clear) begin
      err_d   = '0;
      ffval_d = 1'b0;
      pass_d  = 1'b0;
    end else if (mismatch_c) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (!ffval_q) begin
        ffv_d   = vec;
        ffval_d = 1'b1;
      end
    end
    if (finalize) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      pass_q  <= pass_d;
    end
  end

  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;
  assign pass             = pass_q;

endmodule

// File: rtl/circuit3_test_sequencer.sv
// Exhaustive input sweep controller: drives every vector into the CUT/golden pair,
// waits a settle time, compares z, and reports the result through the logger.
module circuit3_test_sequencer
  import circuit3_tst_pkg::*;
#(
  parameter int unsigned N_IN         = N_IN_DEF,
  parameter int unsigned SETTLE_CYC   = SETTLE_CYC_DEF,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] x_out,
  input  logic            cut_z,
  input  logic            gold_z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0]     VEC_LAST    = N_IN'(vec_last(N_IN));
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [N_IN-1:0]     x_out_q, x_out_d;
  logic [SETTLE_W-1:0] set_q, set_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clear_c, sample_c, finalize_c, mismatch_c;
  logic                run_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // abort wins over every exit, including a STOP_ON_FAIL mismatch
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = APPLY;
      APPLY:   state_d = abort ? IDLE : SETTLE;
      SETTLE: begin
        if (abort)              state_d = IDLE;
        else if (set_q == '0)   state_d = COMPARE;
      end
      COMPARE: begin
        if (abort)                            state_d = IDLE;
        else if (mismatch_c && STOP_ON_FAIL)  state_d = DONE;
        else if (vec_q == VEC_LAST)           state_d = DONE;
        else                                  state_d = APPLY;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d      = vec_q;
    x_out_d    = x_out_q;
    set_d      = set_q;
    done_d     = done_q;
    clear_c    = 1'b0;
    run_c      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == COMPARE);
    sample_c   = (state_q == COMPARE);
    finalize_c = (state_d == DONE);
    busy_d     = (state_d == APPLY) || (state_d == SETTLE) || (state_d == COMPARE);
    case (state_q)
      IDLE: begin
        if (state_d == APPLY) begin
          clear_c = 1'b1;
          vec_d   = '0;
          x_out_d = '0;
          done_d  = 1'b0;
        end
      end
      APPLY:   set_d = SETTLE_LOAD;
      SETTLE:  if (set_q != '0) set_d = set_q - SETTLE_W'(1);
      COMPARE: begin
        if (state_d == APPLY) begin
          vec_d   = vec_q + N_IN'(1);
          x_out_d = vec_q + N_IN'(1);
        end
      end
      default: ;
    endcase
    if (state_d == DONE) done_d = 1'b1;
    if (abort && run_c)  x_out_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      x_out_q <= '0;
      set_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      x_out_q <= x_out_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  circuit3_tst_result_log #(
    .N_IN (N_IN)
  ) u_log (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear_c),
    .sample           (sample_c),
    .finalize         (finalize_c),
    .cut_z            (cut_z),
    .gold_z           (gold_z),
    .vec              (vec_q),
    .mismatch_c       (mismatch_c),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid),
    .pass             (pass)
  );

  assign x_out = x_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_circuit3_test_sequencer.sv
// Scoreboard bench for circuit3_test_sequencer: randomized fault maps, a sweep-level
// reference model, and a monitor that scores each completed run.
module tb_circuit3_test_sequencer;

  localparam int NV   = 32;
  localparam int VLAT = 4;

  typedef struct {
    int err;
    int ffv;
    bit ffval;
    bit pass;
    int lat;
    int xfin;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [31:0] gold_tab = '0, fault_mask = '0;
  logic [4:0]  x0, x1, ffv0, ffv1;
  logic [5:0]  err0, err1;
  logic        cut0, gold0, cut1, gold1;
  logic        busy0, done0, pass0, ffval0, busy1, done1, pass1, ffval1;

  int   cyc = 0, sc0 = 0, sc1 = 0;
  bit   track0 = 1'b0, done0_prev = 1'b0, done1_prev = 1'b0;
  int   tests = 0, fails = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign gold0 = gold_tab[x0];
  assign cut0  = gold_tab[x0] ^ fault_mask[x0];
  assign gold1 = gold_tab[x1];
  assign cut1  = gold_tab[x1] ^ fault_mask[x1];

  circuit3_test_sequencer #(.N_IN(5), .SETTLE_CYC(2), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .x_out(x0),
    .cut_z(cut0), .gold_z(gold0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0), .first_fail_valid(ffval0));

  circuit3_test_sequencer #(.N_IN(5), .SETTLE_CYC(2), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .x_out(x1),
    .cut_z(cut1), .gold_z(gold1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffval1));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-sweep outcome from the fault map: which vectors get compared and what they log.
  function automatic exp_t model(input logic [31:0] m, input bit stop);
    exp_t e;
    int   last;
    e.err = 0; e.ffv = 0; e.ffval = 1'b0; e.pass = 1'b0; e.lat = 0; e.xfin = 0;
    last = NV - 1;
    for (int v = 0; v < NV; v++)
      if (m[v] && !e.ffval) begin
        e.ffval = 1'b1;
        e.ffv   = v;
      end
    if (stop && e.ffval) last = e.ffv;
    for (int v = 0; v <= last; v++) e.err += int'(m[v]);
    e.pass = (e.err == 0);
    e.lat  = VLAT * (last + 1);
    e.xfin = last;
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input int err, input int ffv,
                       input int ffval, input int pss, input int bsy, input int lat,
                       input int x);
    check({tag, "_err_count"}, err, e.err);
    check({tag, "_first_fail_valid"}, ffval, int'(e.ffval));
    if (e.ffval) check({tag, "_first_fail_vec"}, ffv, e.ffv);
    check({tag, "_pass"}, pss, int'(e.pass));
    check({tag, "_busy_at_done"}, bsy, 0);
    check({tag, "_done_latency"}, lat, e.lat);
    check({tag, "_x_out_final"}, x, e.xfin);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && track0 && (cyc - sc0) < NV * VLAT) begin
      check("busy_during_run", int'(busy0), 1);
      check("x_out_step", int'(x0), (cyc - sc0) / VLAT);
    end
    if (rst_n && done0 && !done0_prev) begin
      if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        score("dut0", e, int'(err0), int'(ffv0), int'(ffval0), int'(pass0), int'(busy0),
              cyc - sc0, int'(x0));
      end
    end
    if (rst_n && done1 && !done1_prev) begin
      if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        score("dut1", e, int'(err1), int'(ffv1), int'(ffval1), int'(pass1), int'(busy1),
              cyc - sc1, int'(x1));
      end
    end
    done0_prev <= done0;
    done1_prev <= done1;
  end

  task automatic run(input logic [31:0] m, input logic [31:0] g, input bit inst,
                     input bit trk, input bit poke);
    fault_mask = m;
    gold_tab   = g;
    @(negedge clk);
    if (inst) begin q1.push_back(model(m, 1'b1)); start1 = 1'b1; end
    else      begin q0.push_back(model(m, 1'b0)); start0 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    if (inst) sc1 = cyc; else sc0 = cyc;
    track0 = trk && !inst;
    if (poke) begin
      repeat (40) @(negedge clk);
      if (inst) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
    end
    for (int i = 0; i < 400 && (inst ? q1.size() : q0.size()) != 0; i++) @(posedge clk);
    if ((inst ? q1.size() : q0.size()) != 0) begin
      check("run_done_timeout", 1, 0);
      q0.delete(); q1.delete();
    end
    track0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic abort_run(input logic [31:0] m, input logic [31:0] g, input int at_n);
    int nlog, ff;
    bit ffok;
    fault_mask = m;
    gold_tab   = g;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; sc0 = cyc;
    repeat (at_n + 1) @(negedge clk);
    abort0 = 1'b1;
    @(posedge clk); #1; abort0 = 1'b0;
    nlog = 0; ff = 0; ffok = 1'b0;
    for (int v = 0; v < NV; v++)
      if (m[v] && VLAT * v + (VLAT - 1) <= at_n) begin
        nlog++;
        if (!ffok) begin ffok = 1'b1; ff = v; end
      end
    check("abort_busy", int'(busy0), 0);
    check("abort_x_out", int'(x0), 0);
    check("abort_done", int'(done0), 0);
    check("abort_err_count", int'(err0), nlog);
    check("abort_first_fail_valid", int'(ffval0), int'(ffok));
    if (ffok) check("abort_first_fail_vec", int'(ffv0), ff);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", int'(busy0), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    check("reset_x_out", int'(x0), 0);
    check("reset_busy", int'(busy0), 0);
    check("reset_done", int'(done0), 0);
    check("reset_pass", int'(pass0), 0);
    check("reset_err_count", int'(err0), 0);
    check("reset_first_fail_vec", int'(ffv0), 0);
    check("reset_first_fail_valid", int'(ffval0), 0);
    check("reset_dut1_busy", int'(busy1), 0);
    rst_n = 1'b1;

    run(32'h0, $urandom(), 1'b0, 1'b1, 1'b0);
    run(32'h1 << 12, $urandom(), 1'b0, 1'b0, 1'b1);
    run(32'h0000_03F8, $urandom() | 32'h0000_03F8, 1'b0, 1'b0, 1'b0);
    run((32'h1 << 9) | ($urandom() & 32'hFFFF_FC00), $urandom(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run($urandom() & $urandom() & $urandom(), $urandom(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run($urandom() & $urandom(), $urandom(), 1'b1, 1'b0, 1'b0);
    run(32'h0, $urandom(), 1'b1, 1'b0, 1'b0);

    // start and abort together in IDLE: request dropped, previous result held
    @(negedge clk); start0 = 1'b1; abort0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; abort0 = 1'b0;
    check("start_abort_idle_busy", int'(busy0), 0);
    check("start_abort_done_held", int'(done0), 1);
    repeat (2) @(negedge clk);
    check("start_abort_idle_still", int'(busy0), 0);

    abort_run($urandom() & $urandom(), $urandom(), 21);
    abort_run((32'h1 << 5) | ($urandom() & $urandom()), $urandom(), 23);

    // reset mid-run at vector 20
    fault_mask = $urandom() & $urandom();
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; sc0 = cyc;
    repeat (81) @(negedge clk);
    check("pre_reset_x_out", int'(x0), 20);
    #2; rst_n = 1'b0; #1;
    check("midreset_x_out", int'(x0), 0);
    check("midreset_busy", int'(busy0), 0);
    check("midreset_done", int'(done0), 0);
    check("midreset_pass", int'(pass0), 0);
    check("midreset_err_count", int'(err0), 0);
    check("midreset_first_fail_vec", int'(ffv0), 0);
    check("midreset_first_fail_valid", int'(ffval0), 0);
    @(negedge clk); rst_n = 1'b1;
    run($urandom() & $urandom() & $urandom(), $urandom(), 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
